// File: rtl/mxrv_if_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : mxrv_if_buf_if
// Description : Bundle of the fetch-side and decode-side signals of the
//               instruction-fetch buffer.
//               master : drives bus return data, flush and decode ready
//                        (fetch unit / testbench side)
//               slave  : the buffer itself
//   pc_i, inst_valid_i, inst_data_i : instruction returned by the bus
//   inst_ready_o                    : buffer can accept a push
//   flush_i                         : jump/flush, discards every entry
//   out_ready_i                     : decode accepts the head entry
//   pc_inst_valid_o, pc_o,
//   inst_data_o                     : head entry presented to decode
//   count_o                         : occupancy, 0..DEPTH
//   ovf_o                           : sticky overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
interface mxrv_if_buf_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
);
  logic [ADDR_W-1:0] pc_i;
  logic              inst_valid_i;
  logic [DATA_W-1:0] inst_data_i;
  logic              inst_ready_o;
  logic              flush_i;
  logic              out_ready_i;
  logic              pc_inst_valid_o;
  logic [ADDR_W-1:0] pc_o;
  logic [DATA_W-1:0] inst_data_o;
  logic [CNT_W-1:0]  count_o;
  logic              ovf_o;

  modport master (
    output pc_i, inst_valid_i, inst_data_i, flush_i, out_ready_i,
    input  inst_ready_o, pc_inst_valid_o, pc_o, inst_data_o, count_o, ovf_o
  );

  modport slave (
    input  pc_i, inst_valid_i, inst_data_i, flush_i, out_ready_i,
    output inst_ready_o, pc_inst_valid_o, pc_o, inst_data_o, count_o, ovf_o
  );
endinterface
`default_nettype wire

// File: rtl/mxrv_if_buf.sv
`default_nettype none
// ============================================================================
// Module      : mxrv_if_buf
// Description : DEPTH-entry instruction-fetch buffer. Captures {pc, inst}
//               pairs from the bus and presents the oldest pair to decode
//               through a valid/ready handshake. Flush empties the buffer
//               and clears the sticky overflow flag.
// Ports       : clk   - system clock, rising edge
//               rst_n - synchronous reset, active low
//               bus   - mxrv_if_buf_if.slave (fetch input, decode output,
//                       occupancy and overflow status)
// Revision    : 1.0 - initial release
// ============================================================================
module mxrv_if_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  mxrv_if_buf_if.slave     bus
);

  localparam int              C_PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  // Storage (not reset: contents are only observable through a valid count)
  logic [ADDR_W-1:0]  r_pc_mem   [DEPTH];
  logic [DATA_W-1:0]  r_inst_mem [DEPTH];

  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;

  logic w_ready;
  logic w_valid;
  logic w_push;
  logic w_pop;
  logic w_ovf_event;

  // Ready depends on occupancy only, so a full buffer stays not-ready even
  // in a cycle where decode pops; the freed slot shows up next cycle.
  assign w_ready     = (r_count < C_DEPTH);
  assign w_valid     = (r_count != '0);
  assign w_push      = bus.inst_valid_i &  w_ready & ~bus.flush_i;
  assign w_pop       = w_valid & bus.out_ready_i & ~bus.flush_i;
  assign w_ovf_event = bus.inst_valid_i & ~w_ready & ~bus.flush_i;

  // Pointer/count/flag state. Flush outranks any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else if (bus.flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf_event) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Data write; w_push already excludes reset-less flush/full cases.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_pc_mem[r_wr_ptr]   <= bus.pc_i;
      r_inst_mem[r_wr_ptr] <= bus.inst_data_i;
    end
  end

  // Head is forced to zero when empty so stale storage never leaks out.
  assign bus.inst_ready_o    = w_ready;
  assign bus.pc_inst_valid_o = w_valid;
  assign bus.pc_o            = w_valid ? r_pc_mem[r_rd_ptr]   : '0;
  assign bus.inst_data_o     = w_valid ? r_inst_mem[r_rd_ptr] : '0;
  assign bus.count_o         = r_count;
  assign bus.ovf_o           = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mxrv_if_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_mxrv_if_buf
// Description : Directed self-checking bench for mxrv_if_buf (DEPTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mxrv_if_buf;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mxrv_if_buf_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(3)) bus ();

  mxrv_if_buf #(
    .ADDR_W(32),
    .DATA_W(32),
    .DEPTH (4),
    .CNT_W (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
    bus.inst_valid_i = v;
    bus.pc_i         = pc;
    bus.inst_data_i  = inst;
    bus.out_ready_i  = rdy;
    bus.flush_i      = fl;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // ---- reset ----
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_valid", bus.pc_inst_valid_o, 0);
    check("rst_pc",    bus.pc_o, 0);
    check("rst_inst",  bus.inst_data_o, 0);
    check("rst_count", bus.count_o, 0);
    check("rst_ready", bus.inst_ready_o, 1);
    check("rst_ovf",   bus.ovf_o, 0);

    // ---- fill, decode stalled ----
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(4 * k), 32'(32'hA0 + k), 1'b0, 1'b0);
      tick();
      check("fill_count", bus.count_o, 64'(k + 1));
      check("fill_pc",    bus.pc_o, 64'h0);
      check("fill_inst",  bus.inst_data_o, 64'hA0);
      check("fill_valid", bus.pc_inst_valid_o, 1);
    end
    check("full_ready", bus.inst_ready_o, 0);

    // ---- drain in order ----
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("full_pop_ready", bus.inst_ready_o, 0);
    for (int k = 0; k < 4; k++) begin
      check("drain_pc",   bus.pc_o, 64'(4 * k));
      check("drain_inst", bus.inst_data_o, 64'(32'hA0 + k));
      tick();
    end
    check("drain_valid", bus.pc_inst_valid_o, 0);
    check("drain_pc0",   bus.pc_o, 0);
    check("drain_count", bus.count_o, 0);

    // ---- streaming across pointer wrap ----
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'(32'h100 + 4 * k), 32'(32'hB00 + k), 1'b1, 1'b0);
      tick();
      check("stream_count", bus.count_o, 1);
      check("stream_pc",    bus.pc_o, 64'(32'h100 + 4 * k));
      check("stream_inst",  bus.inst_data_o, 64'(32'hB00 + k));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("stream_empty", bus.count_o, 0);

    // ---- overflow ----
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(32'h10 + 4 * k), 32'(32'hD0 + k), 1'b0, 1'b0);
      tick();
    end
    check("ovf_full", bus.count_o, 4);
    check("ovf_pre",  bus.ovf_o, 0);
    drive(1'b1, 32'h20, 32'hEE, 1'b0, 1'b0);
    tick();
    check("ovf_set",   bus.ovf_o, 1);
    check("ovf_count", bus.count_o, 4);
    check("ovf_head",  bus.pc_o, 64'h10);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check("ovf_hold", bus.ovf_o, 1);
    // Pop one without pushing: count 3, flag still set.
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("ovf_pop_count", bus.count_o, 3);
    check("ovf_pop_head",  bus.pc_o, 64'h14);
    check("ovf_sticky",    bus.ovf_o, 1);

    // ---- flush with concurrent push and pop ----
    drive(1'b1, 32'h40, 32'hF0, 1'b1, 1'b1);
    tick();
    check("flush_count", bus.count_o, 0);
    check("flush_ovf",   bus.ovf_o, 0);
    check("flush_valid", bus.pc_inst_valid_o, 0);
    check("flush_ready", bus.inst_ready_o, 1);
    check("flush_pc",    bus.pc_o, 0);
    // Flush held: still nothing accepted.
    tick();
    check("flush_hold_count", bus.count_o, 0);
    drive(1'b1, 32'h80, 32'hC0, 1'b0, 1'b0);
    tick();
    check("post_flush_valid", bus.pc_inst_valid_o, 1);
    check("post_flush_pc",    bus.pc_o, 64'h80);
    check("post_flush_inst",  bus.inst_data_o, 64'hC0);
    check("post_flush_count", bus.count_o, 1);

    // ---- reset mid-stream ----
    drive(1'b1, 32'h84, 32'hC1, 1'b0, 1'b0);
    tick();
    check("pre_rst_count", bus.count_o, 2);
    rst_n = 1'b0;
    drive(1'b1, 32'h88, 32'hC2, 1'b1, 1'b0);
    tick();
    check("mid_rst_valid", bus.pc_inst_valid_o, 0);
    check("mid_rst_pc",    bus.pc_o, 0);
    check("mid_rst_inst",  bus.inst_data_o, 0);
    check("mid_rst_count", bus.count_o, 0);
    check("mid_rst_ready", bus.inst_ready_o, 1);
    check("mid_rst_ovf",   bus.ovf_o, 0);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check("post_rst_count", bus.count_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
